// File: rtl/flit_packetizer.sv
// Splits a registered multi-flit message into head/body/tail flits on a
// valid/ready link, counting completed packets.
module flit_packetizer #(
  parameter int DW = 16,
  parameter int NF = 4,
  localparam int LW = $clog2(NF + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NF*DW-1:0] msg_i,
  input  logic [LW-1:0]    len_i,
  input  logic             msg_valid_i,
  output logic             msg_ready_o,
  output logic [DW-1:0]    dout,
  output logic             head_o,
  output logic             tail_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [15:0]      pkt_cnt_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]       state;
  logic [NF*DW-1:0] payload;
  logic [LW-1:0]    idx;
  logic [LW-1:0]    last;
  logic             hs;
  logic             accept;

  // Index of the final flit: zero length sends one flit, oversize clamps to NF.
  function automatic logic [LW-1:0] last_index(input logic [LW-1:0] len);
    if (len == '0)
      return '0;
    else if (len > LW'(NF))
      return LW'(NF - 1);
    else
      return len - LW'(1);
  endfunction

  assign valid_o     = (state == SEND);
  assign head_o      = valid_o && (idx == '0);
  assign tail_o      = valid_o && (idx == last);
  assign hs          = valid_o && ready_i;
  assign msg_ready_o = (state == IDLE) || (hs && tail_o);
  assign accept      = msg_valid_i && msg_ready_o;

  // dout follows idx, so it keeps the last flit while idle.
  always_comb begin
    dout = payload[DW-1:0];
    for (int k = 0; k < NF; k++)
      if (idx == LW'(k))
        dout = payload[k*DW +: DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      payload   <= '0;
      idx       <= '0;
      last      <= '0;
      pkt_cnt_o <= '0;
    end else begin
      if (accept) begin
        payload <= msg_i;
        last    <= last_index(len_i);
        idx     <= '0;
        state   <= SEND;
      end else if (hs && tail_o) begin
        state <= IDLE;
      end else if (hs) begin
        idx <= idx + LW'(1);
      end
      if (hs && tail_o)
        pkt_cnt_o <= pkt_cnt_o + 16'd1;
    end
  end

endmodule
